// File: rtl/csla_arb_pkg.sv
// Shared constants, response record and helpers for the adder arbiter.
package csla_arb_pkg;

  localparam int CSLA_W    = 32;
  localparam int N_REQ_MAX = 8;

  // Ceiling log2, never less than 1 so index vectors always have a bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int ID_W = clog2(N_REQ_MAX);

  // Response slot contents: sum, carry-out and owning requester.
  typedef struct packed {
    logic [CSLA_W-1:0] s;
    logic              cout;
    logic [ID_W-1:0]   id;
  } rsp_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/csla32bit.sv
// 32-bit carry-select adder: 4-bit blocks precompute both carry cases and
// the incoming block carry picks one.
module CSLA32Bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);

  localparam int BLK   = 4;
  localparam int N_BLK = 32 / BLK;

  logic [N_BLK:0] carry;

  assign carry[0] = Cin;

  generate
    for (genvar gi = 0; gi < N_BLK; gi++) begin : g_blk
      logic [BLK:0] sum0;
      logic [BLK:0] sum1;
      // Both candidate results, independent of the incoming carry.
      assign sum0 = {1'b0, A[gi*BLK +: BLK]} + {1'b0, B[gi*BLK +: BLK]};
      assign sum1 = {1'b0, A[gi*BLK +: BLK]} + {1'b0, B[gi*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
      assign S[gi*BLK +: BLK] = carry[gi] ? sum1[BLK-1:0] : sum0[BLK-1:0];
      assign carry[gi+1]      = carry[gi] ? sum1[BLK]     : sum0[BLK];
    end
  endgenerate

  assign Cout = carry[N_BLK];

endmodule

// File: rtl/csla_add_arbiter_rr.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter
  import csla_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // Search upward from ptr; the first valid index found wins.
  always_comb begin
    int  p;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    p     = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (!found && req[p]) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = IW'(p);
      end
    end
  end

endmodule

// File: rtl/csla_add_arbiter.sv
// Shared carry-select adder front end: round-robin grant, one registered
// response slot, and a per-requester saved carry for multi-word chains.
module csla_add_arbiter
  import csla_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = CSLA_W,
  localparam int IW    = clog2(N_REQ)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_REQ-1:0]   REQ_VALID,
  output logic [N_REQ-1:0]   REQ_READY,
  input  logic [N_REQ*W-1:0] REQ_A,
  input  logic [N_REQ*W-1:0] REQ_B,
  input  logic [N_REQ-1:0]   REQ_CIN,
  input  logic [N_REQ-1:0]   REQ_CHAIN,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [W-1:0]       RSP_S,
  output logic               RSP_COUT,
  output logic [IW-1:0]      RSP_ID
);

  slot_state_t      state_reg, state_next;
  logic [IW-1:0]    ptr_reg, ptr_next;
  logic [N_REQ-1:0] carry_reg;
  rsp_t             rsp_reg;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    win_idx;
  logic             can_accept;
  logic             accept;
  logic [W-1:0]     win_a, win_b;
  logic             win_cin;
  logic [W-1:0]     add_s;
  logic             add_cout;
  logic             unused_id_bits;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (REQ_VALID),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (win_idx)
  );

  // A new op may enter when the slot is empty or is being drained this cycle.
  always_comb begin
    can_accept = (state_reg == SLOT_EMPTY) || RSP_READY;
    REQ_READY  = grant & {N_REQ{can_accept}};
    accept     = |REQ_READY;
  end

  // Winner operand mux and carry select feeding the shared adder.
  always_comb begin
    win_a   = REQ_A[int'(win_idx)*W +: W];
    win_b   = REQ_B[int'(win_idx)*W +: W];
    win_cin = REQ_CHAIN[win_idx] ? carry_reg[win_idx] : REQ_CIN[win_idx];
  end

  CSLA32Bit u_adder (
    .A    (win_a),
    .B    (win_b),
    .Cin  (win_cin),
    .S    (add_s),
    .Cout (add_cout)
  );

  // Slot FSM next state and the pointer advance past the winner.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      SLOT_EMPTY: if (accept) state_next = SLOT_FULL;
      SLOT_FULL:  if (!accept && RSP_READY) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
    if (accept) begin
      ptr_next = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + IW'(1);
    end
  end

  // State, pointer, saved carries and response capture.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg <= SLOT_EMPTY;
      ptr_reg   <= '0;
      carry_reg <= '0;
      rsp_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (accept) begin
        rsp_reg.s          <= add_s;
        rsp_reg.cout       <= add_cout;
        rsp_reg.id         <= ID_W'(win_idx);
        carry_reg[win_idx] <= add_cout;
      end
    end
  end

  assign RSP_VALID      = (state_reg == SLOT_FULL);
  assign RSP_S          = rsp_reg.s;
  assign RSP_COUT       = rsp_reg.cout;
  assign RSP_ID         = rsp_reg.id[IW-1:0];
  assign unused_id_bits = ^rsp_reg.id;

endmodule

// File: tb/tb_csla_add_arbiter.sv
// Directed self-checking bench for csla_add_arbiter (4 requesters).
module tb_csla_add_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [N-1:0]     REQ_VALID;
  logic [N-1:0]     REQ_READY;
  logic [N*W-1:0]   REQ_A;
  logic [N*W-1:0]   REQ_B;
  logic [N-1:0]     REQ_CIN;
  logic [N-1:0]     REQ_CHAIN;
  logic             RSP_VALID;
  logic             RSP_READY;
  logic [W-1:0]     RSP_S;
  logic             RSP_COUT;
  logic [IW-1:0]    RSP_ID;

  int errors = 0;
  int checks = 0;

  csla_add_arbiter #(.N_REQ(N), .W(W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_CIN   (REQ_CIN),
    .REQ_CHAIN (REQ_CHAIN),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_S     (RSP_S),
    .RSP_COUT  (RSP_COUT),
    .RSP_ID    (RSP_ID)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic chain);
    REQ_VALID[i]       = 1'b1;
    REQ_A[i*W +: W]    = a;
    REQ_B[i*W +: W]    = b;
    REQ_CIN[i]         = cin;
    REQ_CHAIN[i]       = chain;
  endtask

  task automatic check_rsp(input string tag, input logic [W-1:0] s, input logic c, input logic [IW-1:0] id);
    check({tag, "_valid"}, 64'(RSP_VALID), 64'(1));
    check({tag, "_s"},     64'(RSP_S),     64'(s));
    check({tag, "_cout"},  64'(RSP_COUT),  64'(c));
    check({tag, "_id"},    64'(RSP_ID),    64'(id));
  endtask

  initial begin
    RST_N = 1'b0; REQ_VALID = '0; REQ_A = '0; REQ_B = '0;
    REQ_CIN = '0; REQ_CHAIN = '0; RSP_READY = 1'b0;
    step(); step();
    // Reset state
    check("rst_valid", 64'(RSP_VALID), 64'(0));
    check("rst_s",     64'(RSP_S),     64'(0));
    check("rst_cout",  64'(RSP_COUT),  64'(0));
    check("rst_id",    64'(RSP_ID),    64'(0));
    check("rst_ready", 64'(REQ_READY), 64'(0));
    RST_N = 1'b1;
    step();

    // Single op: FFFFFFFF + 1 from requester 0
    set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    #1 check("single_ready", 64'(REQ_READY), 64'h1);
    step();
    REQ_VALID = '0;
    check_rsp("single", 32'h0, 1'b1, 2'd0);
    step();
    check_rsp("single_hold", 32'h0, 1'b1, 2'd0);
    RSP_READY = 1'b1;
    step();
    check("single_drain", 64'(RSP_VALID), 64'(0));

    // Saved carry of requester 0 is 1: chained 0+0 gives 1
    set_req(0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    REQ_VALID = '0;
    check_rsp("carry0", 32'h1, 1'b0, 2'd0);
    step();

    // 64-bit chain on requester 2
    set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    step();
    check_rsp("chain_lo", 32'h0, 1'b1, 2'd2);
    set_req(2, 32'h0, 32'h0, 1'b0, 1'b1);
    #1 check("chain_ready", 64'(REQ_READY), 64'h4);
    step();
    REQ_VALID = '0;
    check_rsp("chain_hi", 32'h1, 1'b0, 2'd2);
    step();

    // Chain isolation: requester 1 carries out, requester 3 chains from its own zero carry
    set_req(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    step();
    REQ_VALID = '0;
    check_rsp("iso_r1", 32'h0, 1'b1, 2'd1);
    set_req(3, 32'd5, 32'd6, 1'b1, 1'b1);
    step();
    REQ_VALID = '0;
    check_rsp("iso_r3", 32'd11, 1'b0, 2'd3);
    step();

    // Round-robin: all valid, drain every cycle; ptr is 0 here
    for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      check_rsp($sformatf("rr%0d", k), 32'h100 * ((k % N) + 1), 1'b0, IW'(k % N));
    end
    REQ_VALID = '0;
    step();
    check("rr_drain", 64'(RSP_VALID), 64'(0));

    // Backpressure: slot held, pending request waits, then drain+accept together
    set_req(0, 32'd100, 32'd1, 1'b0, 1'b0);
    step();
    REQ_VALID = '0;
    RSP_READY = 1'b0;
    set_req(1, 32'd200, 32'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("bp_ready%0d", k), 64'(REQ_READY), 64'h0);
      step();
      check_rsp($sformatf("bp_hold%0d", k), 32'd101, 1'b0, 2'd0);
    end
    RSP_READY = 1'b1;
    #1 check("bp_release_ready", 64'(REQ_READY), 64'h2);
    step();
    REQ_VALID = '0;
    check_rsp("bp_next", 32'd202, 1'b0, 2'd1);
    step();
    check("bp_drain", 64'(RSP_VALID), 64'(0));

    // Reset mid-stream: set carry of requester 0, then reset while slot is full
    set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    RSP_READY = 1'b0;
    step();
    REQ_VALID = '0;
    check_rsp("pre_rst", 32'h0, 1'b1, 2'd0);
    RST_N = 1'b0;
    step();
    check("mid_rst_valid", 64'(RSP_VALID), 64'(0));
    check("mid_rst_s",     64'(RSP_S),     64'(0));
    RST_N = 1'b1;
    RSP_READY = 1'b1;
    step();
    check("post_rst_valid", 64'(RSP_VALID), 64'(0));
    for (int i = 0; i < N; i++) set_req(i, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 check("post_rst_ptr", 64'(REQ_READY), 64'h1);
    REQ_VALID = '0;
    set_req(0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    REQ_VALID = '0;
    check_rsp("post_rst_chain", 32'h0, 1'b0, 2'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
